pipeline_stall_ctrl: RTL

//  Central sequencer for the 5-stage pipeline register enables and flushes. Combines
//  the load-use stall from hazard detection, I/D memory wait states and EX-stage

---
 rtl/pipeline_stall_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Central sequencer for the 5-stage pipeline register enables and flushes.
// Combines the load-use stall, I/D memory wait states and EX-stage redirects
// into per-stage load/flush controls. A redirect that arrives while the pipe is
// frozen is remembered and applied on the cycle the freeze lifts. Two
// saturating performance counters track stalled cycles and applied redirects.
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   imem_read     in   IF has a fetch outstanding
//   imem_resp     in   instruction memory returns data this cycle
//   dmem_req      in   MEM stage holds a valid load/store
//   dmem_resp     in   data memory completes access this cycle
//   load_use      in   hazard-detection stall request
//   br_taken_ex   in   EX resolves a taken redirect (may be a 1-cycle pulse)
//   pc_load       out  PC register enable
//   if_id_load    out  IF/ID register enable
//   id_ex_load    out  ID/EX register enable
//   ex_mem_load   out  EX/MEM register enable
//   mem_wb_load   out  MEM/WB register enable
//   if_id_flush   out  bubble into IF/ID (meaningful with if_id_load=1)
//   id_ex_flush   out  bubble into ID/EX (meaningful with id_ex_load=1)
//   stall_cycles  out  cycles with pc_load=0 since reset (saturating)
//   flush_count   out  redirects applied since reset (saturating)
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             imem_read,
   input  logic             imem_resp,
   input  logic             dmem_req,
   input  logic             dmem_resp,
   input  logic             load_use,
   input  logic             br_taken_ex,
   output logic             pc_load,
   output logic             if_id_load,
   output logic             id_ex_load,
   output logic             ex_mem_load,
   output logic             mem_wb_load,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StHold   = 2'd1,
      StHoldRd = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic freeze;
   logic redirect;
   logic redirect_applied;

   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   assign freeze   = (imem_read & ~imem_resp) | (dmem_req & ~dmem_resp);
   assign redirect = (state_q == StHoldRd) | br_taken_ex;

   // A redirect only takes effect on an advancing (unfrozen) cycle.
   assign redirect_applied = rst_n & ~freeze & redirect;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun, StHold: begin
            if (freeze) begin
               state_d = br_taken_ex ? StHoldRd : StHold;
            end else begin
               state_d = StRun;
            end
         end
         // EX is frozen, so further br_taken_ex is the same branch: ignore it.
         StHoldRd: begin
            state_d = freeze ? StHoldRd : StRun;
         end
         default: state_d = StRun;
      endcase
   end

   // Output logic (combinational, priority ordered)
   always_comb begin
      pc_load     = 1'b0;
      if_id_load  = 1'b0;
      id_ex_load  = 1'b0;
      ex_mem_load = 1'b0;
      mem_wb_load = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (!rst_n || freeze) begin
         // everything held
      end else if (redirect) begin
         // Redirect outranks load_use: the stalled ID instruction is squashed anyway.
         pc_load     = 1'b1;
         if_id_load  = 1'b1;
         id_ex_load  = 1'b1;
         ex_mem_load = 1'b1;
         mem_wb_load = 1'b1;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         id_ex_load  = 1'b1;
         id_ex_flush = 1'b1;
         ex_mem_load = 1'b1;
         mem_wb_load = 1'b1;
      end else begin
         pc_load     = 1'b1;
         if_id_load  = 1'b1;
         id_ex_load  = 1'b1;
         ex_mem_load = 1'b1;
         mem_wb_load = 1'b1;
      end
   end

   // Saturating performance counters
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (!pc_load && (stall_q != CntMax)) begin
         stall_d = stall_q + CntOne;
      end
      if (redirect_applied && (flush_q != CntMax)) begin
         flush_d = flush_q + CntOne;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;

endmodule
